// File: rtl/seg_disp_pkg.sv
// Shared constants for the seven-segment scanner: glyph table, blank pattern and width helper.
package seg_disp_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned BRIGHT_W = 4;
  localparam int unsigned SUB_SLOTS = 16;

  // Active-high patterns, bit order g..a
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'b0111111;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'b1011011;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'b1001111;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'b1100110;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'b1101101;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'b1111101;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'b0000111;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'b1101111;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'b1110111;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'b1111100;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'b0111001;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'b1011110;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'b1111001;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'b1110001;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  localparam logic [15:0][SEG_W-1:0] GLYPH_TABLE = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned slot_cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to seven-segment pattern with selectable output polarity.
module seg_hex_decoder
  import seg_disp_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    pattern_c
);

  logic [SEG_W-1:0] glyph_c;

  always_comb begin
    glyph_c   = GLYPH_TABLE[nibble];
    pattern_c = ACTIVE_LOW ? ~glyph_c : glyph_c;
  end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed NUM_DIGITS seven-segment scanner with frame-latched shadow data and PWM brightness.
// Optional blink support is compiled in with `define SEG_BLINK_EN.
module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter int unsigned CLK_DIV        = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter int unsigned BLINK_FRAMES   = 250
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]          dp,
  input  logic [NUM_DIGITS-1:0]          digit_en,
  input  logic [BRIGHT_W-1:0]            brightness,
  input  logic [NUM_DIGITS-1:0]          blink_mask,
  output logic [SEG_W-1:0]               seg,
  output logic                           dp_out,
  output logic [NUM_DIGITS-1:0]          sel,
  output logic                           frame_tick
);

  localparam int unsigned CNT_W   = slot_cnt_width(CLK_DIV);
  localparam int unsigned IDX_W   = slot_cnt_width(NUM_DIGITS);
  localparam int unsigned PRE_DIV = CLK_DIV / SUB_SLOTS;
  localparam int unsigned PRE_W   = slot_cnt_width(PRE_DIV);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRE_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  localparam logic [SEG_W-1:0]      SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
  localparam logic                  DP_IDLE  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = SEL_ACTIVE_LOW ? '1 : '0;

  logic [CNT_W-1:0]    slot_cnt, slot_cnt_nxt;
  logic [PRE_W-1:0]    pre_cnt, pre_cnt_nxt;
  logic [BRIGHT_W-1:0] sub_idx, sub_idx_nxt;
  logic [IDX_W-1:0]    scan_idx, scan_idx_nxt;

  logic [NIBBLE_W*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]          sh_dp;
  logic [NUM_DIGITS-1:0]          sh_den;

  logic                  latch_c;
  logic [NIBBLE_W-1:0]   nibble_c;
  logic                  dp_bit_c;
  logic                  den_bit_c;
  logic [NUM_DIGITS-1:0] onehot_c;
  logic [SEG_W-1:0]      glyph_c;
  logic                  blink_hide_c;
  logic                  show_c;

  logic [SEG_W-1:0]      seg_nxt;
  logic                  dp_out_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;

  // Frame latch happens at the top of digit 0 while scanning
  assign latch_c = en && (slot_cnt == '0) && (scan_idx == '0);

  // Scan counters: slot_cnt within a digit slot, pre_cnt/sub_idx give slot_cnt / (CLK_DIV/16)
  always_comb begin
    slot_cnt_nxt = slot_cnt;
    pre_cnt_nxt  = pre_cnt;
    sub_idx_nxt  = sub_idx;
    scan_idx_nxt = scan_idx;
    if (!en) begin
      slot_cnt_nxt = '0;
      pre_cnt_nxt  = '0;
      sub_idx_nxt  = '0;
      scan_idx_nxt = '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt_nxt = '0;
      pre_cnt_nxt  = '0;
      sub_idx_nxt  = '0;
      scan_idx_nxt = (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
    end else begin
      slot_cnt_nxt = slot_cnt + CNT_W'(1);
      if (pre_cnt == PRE_LAST) begin
        pre_cnt_nxt = '0;
        sub_idx_nxt = sub_idx + BRIGHT_W'(1);
      end else begin
        pre_cnt_nxt = pre_cnt + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      pre_cnt  <= '0;
      sub_idx  <= '0;
      scan_idx <= '0;
    end else begin
      slot_cnt <= slot_cnt_nxt;
      pre_cnt  <= pre_cnt_nxt;
      sub_idx  <= sub_idx_nxt;
      scan_idx <= scan_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_den    <= '0;
    end else if (latch_c) begin
      sh_digits <= digits;
      sh_dp     <= dp;
      sh_den    <= digit_en;
    end
  end

  // Per-digit select; on the latch cycle the incoming data bypasses the shadow so slot 0 is fresh
  always_comb begin
    nibble_c  = '0;
    dp_bit_c  = 1'b0;
    den_bit_c = 1'b0;
    onehot_c  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        nibble_c    = latch_c ? digits[NIBBLE_W*i +: NIBBLE_W] : sh_digits[NIBBLE_W*i +: NIBBLE_W];
        dp_bit_c    = latch_c ? dp[i] : sh_dp[i];
        den_bit_c   = latch_c ? digit_en[i] : sh_den[i];
        onehot_c[i] = 1'b1;
      end
    end
  end

  seg_hex_decoder #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_decoder (
    .nibble    (nibble_c),
    .pattern_c (glyph_c)
  );

`ifdef SEG_BLINK_EN
  localparam int unsigned BF_W = slot_cnt_width(BLINK_FRAMES + 1);

  logic [NUM_DIGITS-1:0] sh_blink;
  logic [BF_W-1:0]       blink_cnt, blink_cnt_nxt;
  logic                  blink_on, blink_on_nxt;

  // blink_cnt counts frames shown in the current phase; the phase flips on the latch that starts a new one
  always_comb begin
    blink_cnt_nxt = blink_cnt;
    blink_on_nxt  = blink_on;
    if (latch_c) begin
      if (blink_cnt == BF_W'(BLINK_FRAMES)) begin
        blink_cnt_nxt = BF_W'(1);
        blink_on_nxt  = ~blink_on;
      end else begin
        blink_cnt_nxt = blink_cnt + BF_W'(1);
      end
    end
  end

  always_comb begin
    blink_hide_c = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        blink_hide_c = (latch_c ? blink_mask[i] : sh_blink[i]) &&
                       !(latch_c ? blink_on_nxt : blink_on);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_blink  <= '0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      blink_on  <= blink_on_nxt;
      if (latch_c) begin
        sh_blink <= blink_mask;
      end
    end
  end
`else
  logic unused_blink;
  assign unused_blink = (^blink_mask) ^ (BLINK_FRAMES == 0);
  assign blink_hide_c = 1'b0;
`endif

  // Registered pin stage, one cycle behind the counter state
  always_comb begin
    show_c     = en && (sub_idx <= brightness) && den_bit_c && !blink_hide_c;
    seg_nxt    = SEG_IDLE;
    dp_out_nxt = DP_IDLE;
    sel_nxt    = SEL_IDLE;
    if (show_c) begin
      seg_nxt    = glyph_c;
      dp_out_nxt = dp_bit_c ^ SEG_ACTIVE_LOW;
      sel_nxt    = SEL_ACTIVE_LOW ? ~onehot_c : onehot_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg        <= SEG_IDLE;
      dp_out     <= DP_IDLE;
      sel        <= SEL_IDLE;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      dp_out     <= dp_out_nxt;
      sel        <= sel_nxt;
      frame_tick <= latch_c;
    end
  end

endmodule
